// File: rtl/mips_sched_pkg.sv
// Shared types and defaults for the two-requester MIPS issue scheduler.
package mips_sched_pkg;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_CORE_LAT   = 2;
    localparam int CNT_W          = 8;

    typedef logic req_id_t;

    // One stage of the in-flight tag pipe: whether an instruction is in
    // flight at this depth and which requester issued it.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/mips_req_fifo.sv
// Per-requester instruction FIFO. Ready is derived from the registered count,
// so a full FIFO refuses a push even when it is popped in the same cycle.
module mips_req_fifo
    import mips_sched_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         ready,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop_ok;

    assign ready  = (count_q != FULL_CNT);
    assign empty  = (count_q == '0);
    assign push   = push_valid && ready;
    assign pop_ok = pop && !empty;
    assign head   = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mips_issue_sched.sv
// Round-robin issue of two instruction streams onto the single-issue MIPS
// core, with response tagging, per-requester statistics and a sticky flag
// for core strobes that disagree with the expected latency.
module mips_issue_sched
    import mips_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CORE_LAT   = DEF_CORE_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [31:0]      req0_instr,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_instr,
    output logic             req1_ready,
    output logic             core_in_valid,
    output logic [31:0]      core_instruction,
    input  logic             core_out_valid,
    input  logic             core_instruction_fail,
    output logic             resp_valid,
    output logic             resp_id,
    output logic             resp_fail,
    output logic [CNT_W-1:0] issue_cnt0,
    output logic [CNT_W-1:0] issue_cnt1,
    output logic [CNT_W-1:0] fail_cnt0,
    output logic [CNT_W-1:0] fail_cnt1,
    output logic             protocol_err
);

    logic [31:0] head0, head1;
    logic        empty0, empty1, pop0, pop1;
    logic        gnt_vld;
    req_id_t     gnt_id;

    req_id_t     last_grant_q, last_grant_d;
    logic        core_in_valid_q, core_in_valid_d;
    logic [31:0] core_instruction_q, core_instruction_d;
    req_id_t     issue_id_q, issue_id_d;
    tag_t [CORE_LAT-1:0]        tag_pipe_q, tag_pipe_d;
    logic [1:0][CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [1:0][CNT_W-1:0]      fail_cnt_q, fail_cnt_d;
    logic        protocol_err_q, protocol_err_d;
    tag_t        tag_last;
    logic        tag_match;

    mips_req_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (req0_valid),
        .push_data  (req0_instr),
        .ready      (req0_ready),
        .pop        (pop0),
        .empty      (empty0),
        .head       (head0)
    );

    mips_req_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (req1_valid),
        .push_data  (req1_instr),
        .ready      (req1_ready),
        .pop        (pop1),
        .empty      (empty1),
        .head       (head1)
    );

    // Arbitrate on registered occupancy; alternate only under contention.
    always_comb begin
        gnt_vld = !empty0 || !empty1;
        if (!empty0 && !empty1) gnt_id = ~last_grant_q;
        else                    gnt_id = empty0;
        pop0 = gnt_vld && (gnt_id == 1'b0);
        pop1 = gnt_vld && (gnt_id == 1'b1);
    end

    assign tag_last   = tag_pipe_q[CORE_LAT-1];
    assign tag_match  = (core_out_valid == tag_last.valid);
    assign resp_valid = core_out_valid;
    assign resp_fail  = core_out_valid && core_instruction_fail;
    assign resp_id    = tag_match ? tag_last.id : 1'b0;

    // Next-state for issue register, tag pipe, statistics and error flag.
    always_comb begin
        last_grant_d       = gnt_vld ? gnt_id : last_grant_q;
        core_in_valid_d    = gnt_vld;
        core_instruction_d = gnt_vld ? (gnt_id ? head1 : head0) : core_instruction_q;
        issue_id_d         = gnt_vld & gnt_id;

        tag_pipe_d[0].valid = core_in_valid_q;
        tag_pipe_d[0].id    = core_in_valid_q & issue_id_q;
        for (int i = 1; i < CORE_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];

        issue_cnt_d = issue_cnt_q;
        if (gnt_vld) issue_cnt_d[gnt_id] = issue_cnt_q[gnt_id] + 1'b1;

        fail_cnt_d = fail_cnt_q;
        if (resp_fail && (fail_cnt_q[resp_id] != '1))
            fail_cnt_d[resp_id] = fail_cnt_q[resp_id] + 1'b1;

        protocol_err_d = protocol_err_q || !tag_match;
    end

    // All scheduler state; last_grant starts at 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q       <= 1'b1;
            core_in_valid_q    <= 1'b0;
            core_instruction_q <= '0;
            issue_id_q         <= 1'b0;
            tag_pipe_q         <= '0;
            issue_cnt_q        <= '0;
            fail_cnt_q         <= '0;
            protocol_err_q     <= 1'b0;
        end else begin
            last_grant_q       <= last_grant_d;
            core_in_valid_q    <= core_in_valid_d;
            core_instruction_q <= core_instruction_d;
            issue_id_q         <= issue_id_d;
            tag_pipe_q         <= tag_pipe_d;
            issue_cnt_q        <= issue_cnt_d;
            fail_cnt_q         <= fail_cnt_d;
            protocol_err_q     <= protocol_err_d;
        end
    end

    assign core_in_valid    = core_in_valid_q;
    assign core_instruction = core_instruction_q;
    assign issue_cnt0       = issue_cnt_q[0];
    assign issue_cnt1       = issue_cnt_q[1];
    assign fail_cnt0        = fail_cnt_q[0];
    assign fail_cnt1        = fail_cnt_q[1];
    assign protocol_err     = protocol_err_q;

endmodule
